// File: rtl/regfile_wb_scheduler.sv
// Register-file write-back scheduler: round-robin ALU/load arbitration onto a single
// registered write port, plus a pending-write scoreboard for RAW/WAW hazard detection.
module regfile_wb_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NREGS      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic                  rsv_stall,
  input  logic [ADDR_WIDTH-1:0] chk_addr_a,
  input  logic [ADDR_WIDTH-1:0] chk_addr_b,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr_c,
  output logic [DATA_WIDTH-1:0] data_c,
  output logic [NREGS-1:0]      busy_vec
);

  typedef enum logic {
    PRI_ALU,
    PRI_LD
  } pri_t;

  pri_t pri_q, pri_d;

  logic [NREGS-1:0] busy_d;
  logic             grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= PRI_ALU;
    end else begin
      pri_q <= pri_d;
    end
  end

  // The priority pointer only moves when both requesters compete.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    pri_d     = pri_q;
    if (!rst) begin
      if (alu_valid && ld_valid) begin
        if (pri_q == PRI_ALU) begin
          alu_ready = 1'b1;
          pri_d     = PRI_LD;
        end else begin
          ld_ready = 1'b1;
          pri_d    = PRI_ALU;
        end
      end else begin
        alu_ready = alu_valid;
        ld_ready  = ld_valid;
      end
    end
  end

  assign grant = alu_ready || ld_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      we     <= 1'b0;
      addr_c <= '0;
      data_c <= '0;
    end else begin
      we <= grant;
      if (alu_ready) begin
        addr_c <= alu_addr;
        data_c <= alu_data;
      end else if (ld_ready) begin
        addr_c <= ld_addr;
        data_c <= ld_data;
      end
    end
  end

  assign rsv_stall = !rst && rsv_valid && busy_vec[rsv_addr];
  assign busy_a    = busy_vec[chk_addr_a];
  assign busy_b    = busy_vec[chk_addr_b];

  // Set is applied after clear so a same-edge set/clear on one register leaves it pending.
  always_comb begin
    busy_d = busy_vec;
    if (we) begin
      busy_d[addr_c] = 1'b0;
    end
    if (rsv_valid && !rsv_stall) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: arbitration, write port, scoreboard, reset.
module tb_regfile_wb_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          rsv_valid;
  logic [AW-1:0] rsv_addr;
  logic          rsv_stall;
  logic [AW-1:0] chk_addr_a;
  logic [AW-1:0] chk_addr_b;
  logic          busy_a;
  logic          busy_b;
  logic          we;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] data_c;
  logic [NR-1:0] busy_vec;

  int checks = 0;
  int errors = 0;

  regfile_wb_scheduler #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NREGS(NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .alu_valid(alu_valid),
    .alu_addr(alu_addr),
    .alu_data(alu_data),
    .alu_ready(alu_ready),
    .ld_valid(ld_valid),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .ld_ready(ld_ready),
    .rsv_valid(rsv_valid),
    .rsv_addr(rsv_addr),
    .rsv_stall(rsv_stall),
    .chk_addr_a(chk_addr_a),
    .chk_addr_b(chk_addr_b),
    .busy_a(busy_a),
    .busy_b(busy_b),
    .we(we),
    .addr_c(addr_c),
    .data_c(data_c),
    .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h11;
    ld_valid = 1'b0;  ld_addr = '0;    ld_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    chk_addr_a = '0;  chk_addr_b = '0;

    // 1. reset with ALU request held
    tick();
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_busy_vec", busy_vec, 0);
    chk("rst_addr_c", addr_c, 0);
    chk("rst_data_c", data_c, 0);
    tick();
    chk("rst2_alu_ready", alu_ready, 0);
    chk("rst2_we", we, 0);
    rst = 1'b0;
    #1;
    chk("rel_alu_ready", alu_ready, 1);
    chk("rel_ld_ready", ld_ready, 0);
    tick();
    alu_valid = 1'b0;
    chk("rel_we", we, 1);
    chk("rel_addr_c", addr_c, 7);
    chk("rel_data_c", data_c, 32'h11);

    // 2. single ALU write, then hold
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'd4;
    #1;
    chk("single_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("single_we", we, 1);
    chk("single_addr_c", addr_c, 5);
    chk("single_data_c", data_c, 4);
    #1;
    chk("idle_alu_ready", alu_ready, 0);
    tick();
    chk("hold_we", we, 0);
    chk("hold_addr_c", addr_c, 5);
    chk("hold_data_c", data_c, 4);

    // 3. contention alternates ALU, LD, ALU, LD
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'd7;
    ld_valid  = 1'b1; ld_addr  = 5'd2; ld_data  = 32'd9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
      chk("cont_ld_ready", ld_ready, (i % 2 == 0) ? 0 : 1);
      tick();
      chk("cont_we", we, 1);
      chk("cont_addr_c", addr_c, (i % 2 == 0) ? 1 : 2);
      chk("cont_data_c", data_c, (i % 2 == 0) ? 7 : 9);
    end
    alu_valid = 1'b0; ld_valid = 1'b0;

    // 4. scoreboard reserve, WAW stall, clear on commit
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    chk_addr_a = 5'd10; chk_addr_b = 5'd11;
    #1;
    chk("rsv10_stall", rsv_stall, 0);
    tick();
    rsv_valid = 1'b0;
    #1;
    chk("rsv10_busy_vec", busy_vec, 64'h400);
    chk("rsv10_busy_a", busy_a, 1);
    chk("rsv10_busy_b", busy_b, 0);
    rsv_valid = 1'b1; rsv_addr = 5'd10;
    #1;
    chk("waw_stall", rsv_stall, 1);
    tick();
    rsv_valid = 1'b0;
    chk("waw_busy_vec", busy_vec, 64'h400);
    ld_valid = 1'b1; ld_addr = 5'd10; ld_data = 32'hAB;
    #1;
    chk("ld10_ready", ld_ready, 1);
    chk("ld10_alu_ready", alu_ready, 0);
    tick();
    ld_valid = 1'b0;
    #1;
    chk("ld10_we", we, 1);
    chk("ld10_addr_c", addr_c, 10);
    chk("ld10_data_c", data_c, 32'hAB);
    chk("ld10_busy_nobypass", busy_a, 1);
    tick();
    chk("ld10_cleared", busy_vec, 0);
    chk("ld10_busy_a", busy_a, 0);
    chk("ld10_we_off", we, 0);

    // 5. reserve colliding with commit of the same register
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_valid = 1'b0;
    chk("rsv3_busy_vec", busy_vec, 64'h8);
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
    #1;
    chk("alu3_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("alu3_we", we, 1);
    chk("alu3_addr_c", addr_c, 3);
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    #1;
    chk("coll_stall", rsv_stall, 1);
    tick();
    rsv_valid = 1'b0;
    chk("coll_busy_vec", busy_vec, 0);
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    #1;
    chk("rsv3b_stall", rsv_stall, 0);
    tick();
    rsv_valid = 1'b0;
    chk("rsv3b_busy_vec", busy_vec, 64'h8);
    // unreserved write to r4 committing while r4 is reserved: set wins
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
    tick();
    alu_valid = 1'b0;
    chk("alu4_we", we, 1);
    chk("alu4_addr_c", addr_c, 4);
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    #1;
    chk("setwin_stall", rsv_stall, 0);
    tick();
    rsv_valid = 1'b0;
    chk("setwin_busy_vec", busy_vec, 64'h18);

    // 6. reset mid-operation; pointer first moved to LD priority
    alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h80;
    ld_valid  = 1'b1; ld_addr  = 5'd9; ld_data  = 32'h90;
    #1;
    chk("pre_cont_alu_ready", alu_ready, 1);
    tick();
    ld_valid = 1'b0;
    alu_addr = 5'd6; alu_data = 32'h66;
    #1;
    chk("r6_alu_ready", alu_ready, 1);
    tick();
    chk("r6_we", we, 1);
    chk("r6_addr_c", addr_c, 6);
    rst = 1'b1;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    #1;
    chk("midrst_alu_ready", alu_ready, 0);
    chk("midrst_stall", rsv_stall, 0);
    tick();
    chk("midrst_we", we, 0);
    chk("midrst_busy_vec", busy_vec, 0);
    chk("midrst_addr_c", addr_c, 0);
    chk("midrst_data_c", data_c, 0);
    tick();
    chk("midrst2_we", we, 0);
    chk("midrst2_busy_vec", busy_vec, 0);
    rst = 1'b0;
    rsv_valid = 1'b0;
    alu_addr = 5'd12; alu_data = 32'hC0;
    ld_valid = 1'b1; ld_addr = 5'd13; ld_data = 32'hD0;
    #1;
    chk("post_rst_alu_ready", alu_ready, 1);
    chk("post_rst_ld_ready", ld_ready, 0);
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0;
    chk("post_rst_addr_c", addr_c, 12);
    chk("post_rst_data_c", data_c, 32'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
